// File: rtl/trace_lane_buffer.sv
// rtl/trace_lane_buffer.sv - lane-compacting retire-trace FIFO with a valid/ready drain port
//
// Purpose:
//   Accepts up to NUM_LANES retired instructions per cycle, packs the valid lanes in
//   ascending lane order into a DEPTH-entry circular buffer, and presents one entry per
//   cycle to the trace sink. A retire group either fits completely or is dropped
//   completely; drops set a sticky overflow flag and bump a saturating drop counter.
//
// Ports:
//   clk, rst_l                        clock, asynchronous active-low reset
//   in_valid/in_exc/in_intr           per-lane retire, exception and interrupt flags
//   in_insn/in_addr                   per-lane instruction and PC, lane i at [32i+31:32i]
//   in_ecause/in_tval                 cause and tval shared by all lanes of the group
//   ovf_clr                           clears overflow and drop_cnt
//   out_valid/out_ready               head handshake
//   out_insn/out_addr/out_exc/out_intr/out_ecause/out_tval   head entry fields
//   out_tstamp                        head timestamp (only with TRACE_BUF_TIMESTAMP_EN)
//   count                             occupied entries
//   overflow/drop_cnt                 sticky drop flag, saturating dropped-group count
//
// Build option: define TRACE_BUF_TIMESTAMP_EN to add a free-running TS_W timestamp
// counter, per-entry timestamp storage and the out_tstamp port.
module trace_lane_buffer #(
  parameter int NUM_LANES = 3,
  parameter int DEPTH     = 8,
  parameter int TS_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic [NUM_LANES-1:0]       in_valid,
  input  logic [NUM_LANES*32-1:0]    in_insn,
  input  logic [NUM_LANES*32-1:0]    in_addr,
  input  logic [NUM_LANES-1:0]       in_exc,
  input  logic [NUM_LANES-1:0]       in_intr,
  input  logic [4:0]                 in_ecause,
  input  logic [31:0]                in_tval,
  input  logic                       ovf_clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_insn,
  output logic [31:0]                out_addr,
  output logic                       out_exc,
  output logic                       out_intr,
  output logic [4:0]                 out_ecause,
  output logic [31:0]                out_tval,
`ifdef TRACE_BUF_TIMESTAMP_EN
  output logic [TS_W-1:0]            out_tstamp,
`endif
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (NUM_LANES < 1 || NUM_LANES > 4 || DEPTH < NUM_LANES || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_bad_params
    $error("trace_lane_buffer: illegal parameter combination");
  end

  logic [31:0] insn_mem   [DEPTH];
  logic [31:0] addr_mem   [DEPTH];
  logic        exc_mem    [DEPTH];
  logic        intr_mem   [DEPTH];
  logic [4:0]  ecause_mem [DEPTH];
  logic [31:0] tval_mem   [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_idx [NUM_LANES];
  logic [CW-1:0] n;
  logic [CW-1:0] acc;
  logic          push;
  logic          drop;
  logic          pop;

  // Each valid lane lands at wr_ptr plus the number of valid lanes below it, so
  // invalid lanes leave no hole. PW-bit addition wraps modulo DEPTH.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      wr_idx[i] = wr_ptr + acc[PW-1:0];
      acc       = acc + {{PW{1'b0}}, in_valid[i]};
    end
    n = acc;
  end

  // Admission compares against the pre-cycle count: a same-cycle pop does not
  // make room for this cycle's group.
  always_comb begin
    push = (n != '0) && (n <= (DEPTH_C - count));
    drop = (n != '0) && !push;
    pop  = out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + n[PW-1:0];
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (push ? n : '0) - {{PW{1'b0}}, pop};
    end
  end

  // A drop in the same cycle as ovf_clr wins and restarts the counter at 1.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= ovf_clr ? 8'd1 : ((drop_cnt == 8'hFF) ? 8'hFF : drop_cnt + 8'd1);
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  // Entry storage carries no reset; only occupied entries are ever observed.
  // Cause/tval are zeroed for lanes without a trap so the sink never sees stale values.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (in_valid[i]) begin
          insn_mem[wr_idx[i]]   <= in_insn[32*i +: 32];
          addr_mem[wr_idx[i]]   <= in_addr[32*i +: 32];
          exc_mem[wr_idx[i]]    <= in_exc[i];
          intr_mem[wr_idx[i]]   <= in_intr[i];
          ecause_mem[wr_idx[i]] <= (in_exc[i] | in_intr[i]) ? in_ecause : 5'd0;
          tval_mem[wr_idx[i]]   <= (in_exc[i] | in_intr[i]) ? in_tval : 32'd0;
        end
      end
    end
  end

`ifdef TRACE_BUF_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (in_valid[i]) ts_mem[wr_idx[i]] <= ts_cnt;
      end
    end
  end

  assign out_tstamp = ts_mem[rd_ptr];
`endif

  assign out_valid  = (count != '0);
  assign out_insn   = insn_mem[rd_ptr];
  assign out_addr   = addr_mem[rd_ptr];
  assign out_exc    = exc_mem[rd_ptr];
  assign out_intr   = intr_mem[rd_ptr];
  assign out_ecause = ecause_mem[rd_ptr];
  assign out_tval   = tval_mem[rd_ptr];

endmodule

// File: tb/tb_trace_lane_buffer.sv
// tb/tb_trace_lane_buffer.sv - scoreboard bench for trace_lane_buffer
module tb_trace_lane_buffer;

  localparam int NL    = 3;
  localparam int DEPTH = 8;
  localparam int TS_W  = 16;

  logic            clk = 1'b0;
  logic            rst_l;
  logic [NL-1:0]   in_valid;
  logic [NL*32-1:0] in_insn;
  logic [NL*32-1:0] in_addr;
  logic [NL-1:0]   in_exc;
  logic [NL-1:0]   in_intr;
  logic [4:0]      in_ecause;
  logic [31:0]     in_tval;
  logic            ovf_clr;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_insn;
  logic [31:0]     out_addr;
  logic            out_exc;
  logic            out_intr;
  logic [4:0]      out_ecause;
  logic [31:0]     out_tval;
  logic [TS_W-1:0] out_tstamp;
  logic [3:0]      count;
  logic            overflow;
  logic [7:0]      drop_cnt;

  trace_lane_buffer #(.NUM_LANES(NL), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst_l(rst_l),
    .in_valid(in_valid), .in_insn(in_insn), .in_addr(in_addr),
    .in_exc(in_exc), .in_intr(in_intr), .in_ecause(in_ecause), .in_tval(in_tval),
    .ovf_clr(ovf_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_addr(out_addr), .out_exc(out_exc), .out_intr(out_intr),
    .out_ecause(out_ecause), .out_tval(out_tval),
`ifdef TRACE_BUF_TIMESTAMP_EN
    .out_tstamp(out_tstamp),
`endif
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

`ifndef TRACE_BUF_TIMESTAMP_EN
  assign out_tstamp = '0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_count = 0;
  logic [31:0] lane_insn [NL];
  logic [31:0] lane_addr [NL];
  logic [4:0]  g_ecause;
  logic [31:0] g_tval;
  bit          ts_chk = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic set_grp(input logic [31:0] base);
    for (int i = 0; i < NL; i++) begin
      lane_insn[i] = base + 32'(i);
      lane_addr[i] = 32'h8000_0000 + (base << 4) + 32'(4 * i);
    end
  endtask

  // Drives one cycle of stimulus from posedge+1 and records what the buffer must
  // emit for it; returns at posedge+1 of the following cycle.
  task automatic cycle(input logic [NL-1:0] v, input logic [NL-1:0] e,
                       input logic [NL-1:0] it, input logic rdy, input logic clr);
    int   n;
    bit   pop;
    exp_t x;
    in_valid  = v;
    in_exc    = e;
    in_intr   = it;
    in_ecause = g_ecause;
    in_tval   = g_tval;
    out_ready = rdy;
    ovf_clr   = clr;
    for (int i = 0; i < NL; i++) begin
      in_insn[32*i +: 32] = lane_insn[i];
      in_addr[32*i +: 32] = lane_addr[i];
    end
    n = 0;
    for (int i = 0; i < NL; i++) n += int'(v[i]);
    pop = (m_count != 0) && rdy;
    if (n != 0 && n <= DEPTH - m_count) begin
      for (int i = 0; i < NL; i++) begin
        if (v[i]) begin
          x.insn   = lane_insn[i];
          x.addr   = lane_addr[i];
          x.exc    = e[i];
          x.intr   = it[i];
          x.ecause = (e[i] | it[i]) ? g_ecause : 5'd0;
          x.tval   = (e[i] | it[i]) ? g_tval : 32'd0;
          exp_q.push_back(x);
        end
      end
      m_count += n;
    end
    if (pop) m_count--;
    @(posedge clk);
    #1;
    in_valid = '0;
    ovf_clr  = 1'b0;
  endtask

  // Monitor: every accepted head entry must match the front of the scoreboard.
  logic [TS_W-1:0] ts_prev;
  bit              ts_have = 0;
  always @(negedge clk) begin
    if (rst_l && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_entry got insn=%h required no entry", out_insn);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        if ({out_insn, out_addr, out_exc, out_intr, out_ecause, out_tval} !==
            {x.insn, x.addr, x.exc, x.intr, x.ecause, x.tval}) begin
          errors++;
          $display("FAIL entry got insn=%h addr=%h exc=%b intr=%b ecause=%0d tval=%h required insn=%h addr=%h exc=%b intr=%b ecause=%0d tval=%h",
                   out_insn, out_addr, out_exc, out_intr, out_ecause, out_tval,
                   x.insn, x.addr, x.exc, x.intr, x.ecause, x.tval);
        end
      end
`ifdef TRACE_BUF_TIMESTAMP_EN
      if (ts_chk) begin
        if (ts_have) begin
          checks++;
          if (out_tstamp !== ts_prev + TS_W'(1)) begin
            errors++;
            $display("FAIL tstamp_step got %h required %h", out_tstamp, ts_prev + TS_W'(1));
          end
        end
        ts_prev = out_tstamp;
        ts_have = 1;
      end else begin
        ts_have = 0;
      end
`endif
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_l = 1'b0; in_valid = '0; in_insn = '0; in_addr = '0; in_exc = '0; in_intr = '0;
    in_ecause = '0; in_tval = '0; ovf_clr = 1'b0; out_ready = 1'b0;
    g_ecause = '0; g_tval = '0;
    set_grp(32'h100);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst_l = 1'b1;
    @(posedge clk);
    #1;

    // Compaction: lanes 0 and 2 valid, lane 1 junk.
    lane_insn[0] = 32'h0000_0013; lane_insn[1] = 32'hFFFF_FFFF; lane_insn[2] = 32'h0010_0093;
    lane_addr[0] = 32'h0000_1000; lane_addr[1] = 32'h0000_1004; lane_addr[2] = 32'h0000_1008;
    cycle(3'b101, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("cmp_first_valid", 32'(out_valid), 32'd1);
    chk("cmp_first_insn", out_insn, 32'h0000_0013);
    cycle(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("cmp_second_insn", out_insn, 32'h0010_0093);
    cycle(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("cmp_empty_valid", 32'(out_valid), 32'd0);

    // Overflow, all-or-nothing admission, clear.
    set_grp(32'h200);
    cycle(3'b111, 3'b000, 3'b000, 1'b0, 1'b0);
    chk("ovf_count3", 32'(count), 32'd3);
    set_grp(32'h210);
    cycle(3'b111, 3'b000, 3'b000, 1'b0, 1'b0);
    chk("ovf_count6", 32'(count), 32'd6);
    set_grp(32'h220);
    cycle(3'b111, 3'b000, 3'b000, 1'b0, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop1", 32'(drop_cnt), 32'd1);
    chk("ovf_count_held", 32'(count), 32'd6);
    set_grp(32'h230);
    cycle(3'b011, 3'b000, 3'b000, 1'b0, 1'b0);
    chk("ovf_count_full", 32'(count), 32'd8);
    cycle(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
    chk("clr_overflow", 32'(overflow), 32'd0);
    chk("clr_drop_cnt", 32'(drop_cnt), 32'd0);

    // Full with simultaneous pop: the pop does not admit the new group.
    set_grp(32'h240);
    cycle(3'b001, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("sim_count7", 32'(count), 32'd7);
    chk("sim_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("sim_overflow", 32'(overflow), 32'd1);

    // Drop coincident with ovf_clr: drop wins, counter restarts at 1.
    set_grp(32'h250);
    cycle(3'b111, 3'b000, 3'b000, 1'b0, 1'b1);
    chk("drop_wins_flag", 32'(overflow), 32'd1);
    chk("drop_wins_cnt", 32'(drop_cnt), 32'd1);
    chk("drop_wins_count", 32'(count), 32'd7);

    repeat (7) cycle(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("drain_count", 32'(count), 32'd0);
    cycle(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("ready_on_empty_count", 32'(count), 32'd0);
    chk("ready_on_empty_valid", 32'(out_valid), 32'd0);

    // Exception on lane 1, then interrupt on lane 2 of a sparse group.
    set_grp(32'h300);
    g_ecause = 5'd2; g_tval = 32'hDEAD_BEEF;
    cycle(3'b111, 3'b010, 3'b000, 1'b0, 1'b0);
    chk("exc_head_ecause", 32'(out_ecause), 32'd0);
    chk("exc_head_tval", out_tval, 32'd0);
    set_grp(32'h310);
    g_ecause = 5'd7; g_tval = 32'h1234_5678;
    cycle(3'b101, 3'b000, 3'b100, 1'b0, 1'b0);
    chk("exc_count5", 32'(count), 32'd5);
    g_ecause = 5'd0; g_tval = 32'd0;
    repeat (5) cycle(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("exc_drain_count", 32'(count), 32'd0);

    // Single-lane stream across several pointer wraps.
    ts_chk = 1;
    for (int k = 0; k < 20; k++) begin
      set_grp(32'h400 + 32'(k * 8));
      cycle(3'b001, 3'b000, 3'b000, 1'b1, 1'b0);
    end
    cycle(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    ts_chk = 0;
    chk("wrap_count", 32'(count), 32'd0);

    // Asynchronous reset with five entries queued and overflow set.
    set_grp(32'h500);
    cycle(3'b111, 3'b000, 3'b000, 1'b0, 1'b0);
    set_grp(32'h510);
    cycle(3'b011, 3'b000, 3'b000, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd5);
    chk("pre_rst_overflow", 32'(overflow), 32'd1);
    rst_l = 1'b0;
    #2;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    chk("arst_drop_cnt", 32'(drop_cnt), 32'd0);
    exp_q.delete();
    m_count = 0;
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    cycle(3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("post_rst_count", 32'(count), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
